goertzel_coef_loader: RTL

- Sequences loading of Goertzel per-bin coefficients from a shared coefficient memory into the goertzel_dft coefficient bank.
- Replaces the free-running start/wait handshake at the MFCC accelerator top level.
- Stalls the framing/DFT datapath only at a frame boundary, fetches one coefficient per bin, and writes it into the bank.
- Reports done or error to the accelerator top level.

---
 rtl/mfcc_pkg.sv | 18 +
 rtl/goertzel_coef_loader_timeout_counter.sv | 27 ++
 rtl/goertzel_coef_loader.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/mfcc_pkg.sv
// Shared MFCC accelerator definitions: the coefficient-loader FSM encoding,
// the default bank geometry and the bin-index width.
package mfcc_pkg;

   localparam int NUM_BINS_DEF = 40;
   localparam int COEF_W_DEF   = 16;
   localparam int BIN_IDX_W    = 6;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_QUIESCE   = 3'd1,
      ST_FETCH     = 3'd2,
      ST_WAIT_DATA = 3'd3,
      ST_WRITE     = 3'd4,
      ST_DONE      = 3'd5
   } gcl_state_t;

endpackage

// File: rtl/goertzel_coef_loader_timeout_counter.sv
// Wait-cycle counter for memory-fetch controllers. expired is high during the
// LIMIT-th consecutive enabled cycle since the last clear.
module gcl_timeout_counter #(
   parameter int LIMIT = 255,
   parameter int CNT_W = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (enable && !expired)
         count <= count + 1'b1;
   end

   assign expired = (count == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/goertzel_coef_loader.sv
// Loads per-bin Goertzel coefficients from shared memory into the DFT bank,
// holding the framing/DFT datapath only across a frame boundary.
// Optional running checksum of written coefficients: define GCL_CHECKSUM_EN.
module goertzel_coef_loader
   import mfcc_pkg::*;
#(
   parameter int NUM_BINS    = NUM_BINS_DEF,
   parameter int COEF_W      = COEF_W_DEF,
   parameter int ADDR_W      = 8,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 load_req,
   input  logic [ADDR_W-1:0]    base_addr,
   input  logic [7:0]           num_bins,
   input  logic                 dft_busy,
   output logic                 dft_hold,
   output logic                 mem_rd_en,
   output logic [ADDR_W-1:0]    mem_addr,
   input  logic [COEF_W-1:0]    mem_rd_data,
   input  logic                 mem_rd_valid,
   output logic                 coef_wr_en,
   output logic [BIN_IDX_W-1:0] coef_wr_idx,
   output logic [COEF_W-1:0]    coef_wr_data,
   output logic                 load_busy,
   output logic                 load_done,
   output logic                 load_err,
`ifdef GCL_CHECKSUM_EN
   output logic [COEF_W+5:0]    coef_sum,
   input  logic [COEF_W+5:0]    expected_sum,
`endif
   output logic [2:0]           state_dbg
);

   localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

   gcl_state_t           state, state_d;
   logic [ADDR_W-1:0]    base_q, base_d;
   logic [BIN_IDX_W:0]   n_q, n_d;
   logic [BIN_IDX_W-1:0] idx_q, idx_d;
   logic                 pending_q, pending_d;
   logic                 accept, timeout, expired;
   logic [7:0]           n_clamped;

   logic                 hold_d, rd_en_d, wr_en_d, busy_d, done_d, err_d;
   logic [ADDR_W-1:0]    addr_d;
   logic [BIN_IDX_W-1:0] wr_idx_d;
   logic [COEF_W-1:0]    wr_data_d;
`ifdef GCL_CHECKSUM_EN
   logic [COEF_W+5:0]    sum_d;
`endif

   assign n_clamped = (num_bins > 8'(NUM_BINS)) ? 8'(NUM_BINS) : num_bins;
   assign timeout   = (state == ST_WAIT_DATA) && !mem_rd_valid && expired;
   assign state_dbg = state;

   gcl_timeout_counter #(.LIMIT(TIMEOUT_CYC), .CNT_W(TO_W)) u_timeout (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (state == ST_FETCH),
      .enable  ((state == ST_WAIT_DATA) && !mem_rd_valid),
      .expired (expired)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         base_q    <= '0;
         n_q       <= '0;
         idx_q     <= '0;
         pending_q <= 1'b0;
      end else begin
         state     <= state_d;
         base_q    <= base_d;
         n_q       <= n_d;
         idx_q     <= idx_d;
         pending_q <= pending_d;
      end
   end

   // Requests arriving while busy collapse into one reload taken at DONE;
   // base/count are re-sampled at that re-entry.
   always_comb begin
      state_d   = state;
      base_d    = base_q;
      n_d       = n_q;
      idx_d     = idx_q;
      pending_d = pending_q;
      accept    = 1'b0;
      if (state != ST_IDLE && load_req)
         pending_d = 1'b1;
      case (state)
         ST_IDLE: begin
            if (load_req) begin
               accept  = 1'b1;
               state_d = ST_QUIESCE;
            end
         end
         ST_QUIESCE: begin
            if (n_q == '0)
               state_d = ST_DONE;
            else if (!dft_busy)
               state_d = ST_FETCH;
         end
         ST_FETCH: state_d = ST_WAIT_DATA;
         ST_WAIT_DATA: begin
            if (mem_rd_valid)
               state_d = ST_WRITE;
            else if (expired) begin
               state_d   = ST_IDLE;
               pending_d = 1'b0;
            end
         end
         ST_WRITE: begin
            if ({1'b0, idx_q} == n_q - 1'b1)
               state_d = ST_DONE;
            else begin
               idx_d   = idx_q + 1'b1;
               state_d = ST_FETCH;
            end
         end
         ST_DONE: begin
            idx_d     = '0;
            pending_d = 1'b0;
            if (pending_q || load_req) begin
               accept  = 1'b1;
               state_d = ST_QUIESCE;
            end else
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (accept) begin
         base_d = base_addr;
         n_d    = n_clamped[BIN_IDX_W:0];
      end
   end

   // Outputs are decoded from the next state so the registers line up with it.
   always_comb begin
      hold_d    = (state_d == ST_QUIESCE) || (state_d == ST_FETCH) ||
                  (state_d == ST_WAIT_DATA) || (state_d == ST_WRITE);
      busy_d    = (state_d != ST_IDLE);
      rd_en_d   = (state_d == ST_FETCH);
      wr_en_d   = (state_d == ST_WRITE);
      addr_d    = mem_addr;
      wr_idx_d  = coef_wr_idx;
      wr_data_d = coef_wr_data;
      done_d    = 1'b0;
      err_d     = load_err;
      if (state_d == ST_FETCH)
         addr_d = base_d + ADDR_W'(idx_d);
      if (state_d == ST_WRITE) begin
         wr_idx_d  = idx_d;
         wr_data_d = mem_rd_data;
      end
      if (accept)
         err_d = 1'b0;
      if (timeout)
         err_d = 1'b1;
`ifdef GCL_CHECKSUM_EN
      sum_d = coef_sum;
      if (accept)
         sum_d = '0;
      if (state_d == ST_WRITE)
         sum_d = coef_sum + (COEF_W + 6)'(mem_rd_data);
      if (state_d == ST_DONE) begin
         if (sum_d == expected_sum)
            done_d = 1'b1;
         else
            err_d = 1'b1;
      end
`else
      if (state_d == ST_DONE)
         done_d = 1'b1;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dft_hold     <= 1'b0;
         mem_rd_en    <= 1'b0;
         mem_addr     <= '0;
         coef_wr_en   <= 1'b0;
         coef_wr_idx  <= '0;
         coef_wr_data <= '0;
         load_busy    <= 1'b0;
         load_done    <= 1'b0;
         load_err     <= 1'b0;
`ifdef GCL_CHECKSUM_EN
         coef_sum     <= '0;
`endif
      end else begin
         dft_hold     <= hold_d;
         mem_rd_en    <= rd_en_d;
         mem_addr     <= addr_d;
         coef_wr_en   <= wr_en_d;
         coef_wr_idx  <= wr_idx_d;
         coef_wr_data <= wr_data_d;
         load_busy    <= busy_d;
         load_done    <= done_d;
         load_err     <= err_d;
`ifdef GCL_CHECKSUM_EN
         coef_sum     <= sum_d;
`endif
      end
   end

endmodule
